// File: rtl/rv32i_id_stage_v2.sv
// RV32I decode stage: operand forwarding, decode-time branch/jump resolution,
// and a hazard FSM for load-use stalls, post-redirect flushes and EBREAK/ECALL halt.
//
// state   | meaning
// S_RUN   | normal decode; hazards, halts and redirects are evaluated here
// S_STALL | load-use bubbles beyond the first; fetch held
// S_FLUSH | NOPs after a taken redirect; iw_in ignored
// S_HALT  | sticky halt after EBREAK/ECALL until reset
module rv32i_id_stage_v2 #(
  parameter int          XLEN      = 32,
  parameter int          NUM_FWD   = 3,
  parameter int          STALL_CYC = 1,
  parameter int          FLUSH_CYC = 1,
  parameter logic [31:0] NOP_IW    = 32'h13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             iw_in,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [XLEN-1:0]         rs1_data_in,
  input  logic [XLEN-1:0]         rs2_data_in,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [5*NUM_FWD-1:0]    fwd_reg,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_is_load,
  output logic [4:0]              rs1_reg,
  output logic [4:0]              rs2_reg,
  output logic [31:0]             iw_out,
  output logic [XLEN-1:0]         pc_out,
  output logic [XLEN-1:0]         rs1_data_out,
  output logic [XLEN-1:0]         rs2_data_out,
  output logic [4:0]              wb_reg,
  output logic                    wb_en_out,
  output logic                    mem_w_en_out,
  output logic                    stall_if,
  output logic                    jump_en_out,
  output logic [XLEN-1:0]         jump_addr,
  output logic                    halted
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1, op2, imm_i, imm_b, imm_j, jalr_sum, target;
  logic            use_rs1, use_rs2, load_use, taken, is_halt, wb_en_dec;
  logic            bubble, stall_c, jump_c;

  assign opcode  = iw_in[6:0];
  assign funct3  = iw_in[14:12];
  assign rs1_reg = iw_in[19:15];
  assign rs2_reg = iw_in[24:20];

  assign imm_i = {{(XLEN-12){iw_in[31]}}, iw_in[31:20]};
  assign imm_b = {{(XLEN-13){iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

  // Lowest source index wins, so sweep from the highest index down.
  always_comb begin
    op1 = rs1_data_in;
    op2 = rs2_data_in;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs1_reg) op1 = fwd_data[XLEN*i +: XLEN];
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs2_reg) op2 = fwd_data[XLEN*i +: XLEN];
    end
    if (rs1_reg == 5'd0) op1 = '0;
    if (rs2_reg == 5'd0) op2 = '0;
  end

  assign use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign load_use = ex_is_load && fwd_en[0] && (fwd_reg[4:0] != 5'd0) &&
                    ((use_rs1 && fwd_reg[4:0] == rs1_reg) || (use_rs2 && fwd_reg[4:0] == rs2_reg));
  assign is_halt = (opcode == OPC_SYSTEM);
  assign wb_en_dec = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                     (opcode == OPC_JALR);
  assign jalr_sum = op1 + imm_i;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (opcode == OPC_JAL) begin
      taken  = 1'b1;
      target = pc_in + imm_j;
    end else if (opcode == OPC_JALR) begin
      taken  = 1'b1;
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (opcode == OPC_BRANCH) begin
      target = pc_in + imm_b;
      case (funct3)
        3'b000:  taken = (op1 == op2);
        3'b001:  taken = (op1 != op2);
        3'b100:  taken = ($signed(op1) <  $signed(op2));
        3'b101:  taken = ($signed(op1) >= $signed(op2));
        3'b110:  taken = (op1 <  op2);
        3'b111:  taken = (op1 >= op2);
        default: taken = 1'b0;
      endcase
    end
  end

  // The RUN cycle that detects a load-use hazard is the first bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bubble    = 1'b1;
    stall_c   = 1'b0;
    jump_c    = 1'b0;
    case (state)
      S_RUN: begin
        if (is_halt) begin
          state_nxt = S_HALT;
        end else if (load_use) begin
          stall_c = 1'b1;
          if (STALL_CYC > 1) begin
            state_nxt = S_STALL;
            cnt_nxt   = 16'(STALL_CYC - 2);
          end
        end else if (taken) begin
          jump_c    = 1'b1;
          bubble    = 1'b0;
          state_nxt = S_FLUSH;
          cnt_nxt   = 16'(FLUSH_CYC - 1);
        end else begin
          bubble = 1'b0;
        end
      end
      S_STALL: begin
        stall_c = 1'b1;
        if (cnt == 16'd0) state_nxt = S_RUN;
        else              cnt_nxt   = cnt - 16'd1;
      end
      S_FLUSH: begin
        if (cnt == 16'd0) state_nxt = S_RUN;
        else              cnt_nxt   = cnt - 16'd1;
      end
      S_HALT: stall_c = 1'b1;
      default: state_nxt = S_RUN;
    endcase
  end

  assign stall_if    = stall_c && !reset;
  assign jump_en_out = jump_c && !reset;
  assign jump_addr   = jump_en_out ? target : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      cnt          <= '0;
      iw_out       <= NOP_IW;
      pc_out       <= '0;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      wb_reg       <= '0;
      wb_en_out    <= 1'b0;
      mem_w_en_out <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      halted <= (state_nxt == S_HALT);
      pc_out <= pc_in;
      if (bubble) begin
        iw_out       <= NOP_IW;
        rs1_data_out <= '0;
        rs2_data_out <= '0;
        wb_reg       <= '0;
        wb_en_out    <= 1'b0;
        mem_w_en_out <= 1'b0;
      end else begin
        iw_out       <= iw_in;
        rs1_data_out <= op1;
        rs2_data_out <= op2;
        wb_reg       <= iw_in[11:7];
        wb_en_out    <= wb_en_dec;
        mem_w_en_out <= (opcode == OPC_STORE);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_id_stage_v2.sv
// Directed bench for rv32i_id_stage_v2: forwarding, load-use stall, redirect/flush,
// branch conditions, halt and reset; hand-encoded instructions and expected values.
module tb_rv32i_id_stage_v2;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD_X3  = 32'h0010_81B3; // add x3,x1,x1
  localparam logic [31:0] ADD_X6  = 32'h0001_0333; // add x6,x2,x0
  localparam logic [31:0] ADD_X5  = 32'h0002_02B3; // add x5,x4,x0
  localparam logic [31:0] SW      = 32'h0020_A023; // sw x2,0(x1)
  localparam logic [31:0] BEQ     = 32'h0000_0863; // beq x0,x0,+16
  localparam logic [31:0] BNE     = 32'h0010_9863; // bne x1,x1,+16
  localparam logic [31:0] BLT     = 32'h0020_C863; // blt x1,x2,+16
  localparam logic [31:0] BLTU    = 32'h0020_E863; // bltu x1,x2,+16
  localparam logic [31:0] JALR    = 32'hFFF1_00E7; // jalr x1,-1(x2)
  localparam logic [31:0] JAL     = 32'h0200_006F; // jal x0,+32
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iw_in, pc_in, rs1_data_in, rs2_data_in;
  logic [2:0]  fwd_en;
  logic [14:0] fwd_reg;
  logic [95:0] fwd_data;
  logic        ex_is_load;
  logic [4:0]  rs1_reg, rs2_reg, wb_reg;
  logic [31:0] iw_out, pc_out, rs1_data_out, rs2_data_out, jump_addr;
  logic        wb_en_out, mem_w_en_out, stall_if, jump_en_out, halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_id_stage_v2 #(.XLEN(32), .NUM_FWD(3), .STALL_CYC(2), .FLUSH_CYC(2), .NOP_IW(32'h13)) dut (
    .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data), .ex_is_load(ex_is_load),
    .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .iw_out(iw_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .wb_reg(wb_reg),
    .wb_en_out(wb_en_out), .mem_w_en_out(mem_w_en_out), .stall_if(stall_if),
    .jump_en_out(jump_en_out), .jump_addr(jump_addr), .halted(halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_fwd(input logic [2:0] en, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    fwd_en   = en;
    fwd_reg  = {r2, r1, r0};
    fwd_data = {d2, d1, d0};
  endtask

  initial begin
    reset = 1'b1; iw_in = BEQ; pc_in = 32'h100; rs1_data_in = 32'h0; rs2_data_in = 32'h0;
    ex_is_load = 1'b0;
    set_fwd(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick; tick;
    chk("rst_iw_out", iw_out, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_rs1_data", rs1_data_out, 32'h0);
    chk("rst_rs2_data", rs2_data_out, 32'h0);
    chk("rst_wb_reg", 32'(wb_reg), 32'h0);
    chk("rst_wb_en", 32'(wb_en_out), 32'h0);
    chk("rst_mem_w", 32'(mem_w_en_out), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stall_if", 32'(stall_if), 32'h0);
    chk("rst_jump_en", 32'(jump_en_out), 32'h0);
    chk("rst_jump_addr", jump_addr, 32'h0);
    reset = 1'b0;

    // EX forwarding of x1 into both operands
    set_fwd(3'b001, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0, 32'h0);
    iw_in = ADD_X3; pc_in = 32'h10; rs1_data_in = 32'hAAAA; rs2_data_in = 32'hBBBB;
    #1;
    chk("t1_rs1_reg", 32'(rs1_reg), 32'd1);
    chk("t1_rs2_reg", 32'(rs2_reg), 32'd1);
    tick;
    chk("t1_iw_out", iw_out, ADD_X3);
    chk("t1_pc_out", pc_out, 32'h10);
    chk("t1_rs1_data", rs1_data_out, 32'd5);
    chk("t1_rs2_data", rs2_data_out, 32'd5);
    chk("t1_wb_reg", 32'(wb_reg), 32'd3);
    chk("t1_wb_en", 32'(wb_en_out), 32'd1);
    chk("t1_mem_w", 32'(mem_w_en_out), 32'd0);

    // Priority EX > MEM > WB, regfile fallback, x0 always zero
    set_fwd(3'b111, 5'd2, 5'd2, 5'd0, 32'd7, 32'd9, 32'hDEAD);
    iw_in = ADD_X6; rs1_data_in = 32'h1111; rs2_data_in = 32'h55;
    tick;
    chk("t2_ex_wins", rs1_data_out, 32'd7);
    chk("t2_x0_zero", rs2_data_out, 32'd0);
    set_fwd(3'b110, 5'd2, 5'd2, 5'd2, 32'd7, 32'd9, 32'd11);
    tick;
    chk("t2_mem_wins", rs1_data_out, 32'd9);
    set_fwd(3'b000, 5'd2, 5'd2, 5'd2, 32'd7, 32'd9, 32'd11);
    tick;
    chk("t2_regfile", rs1_data_out, 32'h1111);

    iw_in = SW; rs1_data_in = 32'h1000; rs2_data_in = 32'h2222;
    tick;
    chk("sw_mem_w", 32'(mem_w_en_out), 32'd1);
    chk("sw_wb_en", 32'(wb_en_out), 32'd0);
    chk("sw_rs2_data", rs2_data_out, 32'h2222);

    // Load-use, two bubbles
    set_fwd(3'b001, 5'd4, 5'd0, 5'd0, 32'hBAD, 32'h0, 32'h0);
    ex_is_load = 1'b1; iw_in = ADD_X5; rs1_data_in = 32'h0;
    #1;
    chk("t3_stall_c0", 32'(stall_if), 32'd1);
    chk("t3_no_jump", 32'(jump_en_out), 32'd0);
    tick;
    chk("t3_bubble1", iw_out, NOP);
    chk("t3_bubble1_wb", 32'(wb_en_out), 32'd0);
    chk("t3_stall_c1", 32'(stall_if), 32'd1);
    tick;
    chk("t3_bubble2", iw_out, NOP);
    ex_is_load = 1'b0;
    set_fwd(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h44, 32'h0);
    #1;
    chk("t3_stall_released", 32'(stall_if), 32'd0);
    tick;
    chk("t3_issue_iw", iw_out, ADD_X5);
    chk("t3_issue_rs1", rs1_data_out, 32'h44);
    chk("t3_issue_wb_reg", 32'(wb_reg), 32'd5);
    chk("t3_issue_wb_en", 32'(wb_en_out), 32'd1);

    // Taken BEQ and two-cycle flush
    set_fwd(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    iw_in = BEQ; pc_in = 32'h100;
    #1;
    chk("t4_jump_en", 32'(jump_en_out), 32'd1);
    chk("t4_jump_addr", jump_addr, 32'h110);
    chk("t4_no_stall", 32'(stall_if), 32'd0);
    tick;
    chk("t4_branch_iw", iw_out, BEQ);
    chk("t4_jump_en_off", 32'(jump_en_out), 32'd0);
    chk("t4_jump_addr_off", jump_addr, 32'h0);
    iw_in = ADD_X3; pc_in = 32'h110;
    tick;
    chk("t4_flush1", iw_out, NOP);
    chk("t4_flush1_wb", 32'(wb_en_out), 32'd0);
    tick;
    chk("t4_flush2", iw_out, NOP);
    tick;
    chk("t4_resume", iw_out, ADD_X3);

    // BNE not taken, then JALR
    iw_in = BNE; pc_in = 32'h200; rs1_data_in = 32'h1234; rs2_data_in = 32'h1234;
    #1;
    chk("t5_bne_jump_en", 32'(jump_en_out), 32'd0);
    chk("t5_bne_jump_addr", jump_addr, 32'h0);
    tick;
    chk("t5_bne_iw", iw_out, BNE);
    iw_in = JALR; pc_in = 32'h300; rs1_data_in = 32'h201;
    #1;
    chk("t5_jalr_jump_en", 32'(jump_en_out), 32'd1);
    chk("t5_jalr_addr", jump_addr, 32'h200);
    tick;
    chk("t5_jalr_iw", iw_out, JALR);
    chk("t5_jalr_wb_en", 32'(wb_en_out), 32'd1);
    chk("t5_jalr_wb_reg", 32'(wb_reg), 32'd1);
    tick; tick;

    // Signed vs unsigned compare on -1 < 1
    iw_in = BLT; pc_in = 32'h40; rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'h1;
    #1;
    chk("blt_taken", 32'(jump_en_out), 32'd1);
    chk("blt_addr", jump_addr, 32'h50);
    tick; tick; tick;
    iw_in = BLTU;
    #1;
    chk("bltu_not_taken", 32'(jump_en_out), 32'd0);
    tick;

    // JAL target wraps modulo 2^32
    iw_in = JAL; pc_in = 32'hFFFF_FFF0;
    #1;
    chk("jal_wrap_addr", jump_addr, 32'h10);
    tick;
    chk("jal_wb_en", 32'(wb_en_out), 32'd1);
    tick; tick;

    // EBREAK halts until reset
    iw_in = EBREAK; pc_in = 32'h500;
    tick;
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_halt_iw", iw_out, NOP);
    iw_in = ADD_X3;
    #1;
    chk("t6_halt_stall", 32'(stall_if), 32'd1);
    tick; tick;
    chk("t6_sticky_iw", iw_out, NOP);
    chk("t6_sticky_halted", 32'(halted), 32'd1);
    chk("t6_sticky_wb", 32'(wb_en_out), 32'd0);
    reset = 1'b1;
    tick;
    chk("t6_rst_halted", 32'(halted), 32'd0);
    chk("t6_rst_iw", iw_out, NOP);
    chk("t6_rst_pc", pc_out, 32'h0);
    chk("t6_rst_stall", 32'(stall_if), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_run_stall", 32'(stall_if), 32'd0);
    tick;
    chk("t6_run_iw", iw_out, ADD_X3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
